// File: rtl/fadd_issue_ctrl.sv
// Issue controller for the 3-stage pipelined single-precision adder: round-robin
// arbitration of two requesters, shadow valid/src/tag pipeline, and result handshake.
module fadd_issue_ctrl #(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              flush,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [31:0]       req0_a,
  input  logic [31:0]       req0_b,
  input  logic [31:0]       req1_a,
  input  logic [31:0]       req1_b,
  input  logic              req0_sub,
  input  logic              req1_sub,
  input  logic [1:0]        req0_rm,
  input  logic [1:0]        req1_rm,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic [31:0]       fa_a,
  output logic [31:0]       fa_b,
  output logic              fa_sub,
  output logic [1:0]        fa_rm,
  output logic              fa_e,
  input  logic [31:0]       fa_s,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_s,
  output logic              res_src,
  output logic [TAG_W-1:0]  res_tag,
  output logic [1:0]        inflight0,
  output logic [1:0]        inflight1
);

  logic             v_c_q, v_c_d, v_n_q, v_n_d;
  logic             src_c_q, src_c_d, src_n_q, src_n_d;
  logic [TAG_W-1:0] tag_c_q, tag_c_d, tag_n_q, tag_n_d;
  logic             prio_q, prio_d;
  logic [1:0]       infl0_q, infl0_d, infl1_q, infl1_d;

  logic             grant0, grant1, issue, res_hs;
  logic [TAG_W-1:0] issue_tag;

  function automatic logic [1:0] infl_step(input logic [1:0] cur,
                                           input logic inc, input logic dec);
    logic [1:0] nxt;
    nxt = cur;
    if (inc && !dec)      nxt = cur + 2'd1;
    else if (dec && !inc) nxt = cur - 2'd1;
    return nxt;
  endfunction

  // Arbitration: grant is purely a function of valids and the round-robin pointer.
  assign grant0 = req0_valid & (~req1_valid | ~prio_q);
  assign grant1 = req1_valid & (~req0_valid |  prio_q);

  // The whole adder pipeline freezes only when the last stage holds an unconsumed sum.
  assign fa_e       = ~(v_n_q & ~res_ready);
  assign req0_ready = fa_e & ~flush & grant0;
  assign req1_ready = fa_e & ~flush & grant1;
  assign issue      = req0_ready | req1_ready;
  assign issue_tag  = grant1 ? req1_tag : req0_tag;
  assign res_hs     = v_n_q & res_ready & ~flush;

  always_comb begin
    fa_a   = '0;
    fa_b   = '0;
    fa_sub = 1'b0;
    fa_rm  = 2'b00;
    if (grant0) begin
      fa_a   = req0_a;
      fa_b   = req0_b;
      fa_sub = req0_sub;
      fa_rm  = req0_rm;
    end else if (grant1) begin
      fa_a   = req1_a;
      fa_b   = req1_b;
      fa_sub = req1_sub;
      fa_rm  = req1_rm;
    end
  end

  always_comb begin
    v_c_d   = v_c_q;
    v_n_d   = v_n_q;
    src_c_d = src_c_q;
    src_n_d = src_n_q;
    tag_c_d = tag_c_q;
    tag_n_d = tag_n_q;
    prio_d  = prio_q;
    infl0_d = infl_step(infl0_q, req0_ready, res_hs & ~src_n_q);
    infl1_d = infl_step(infl1_q, req1_ready, res_hs &  src_n_q);
    if (fa_e) begin
      v_c_d   = issue;
      v_n_d   = v_c_q;
      src_c_d = grant1;
      src_n_d = src_c_q;
      tag_c_d = issue_tag;
      tag_n_d = tag_c_q;
    end
    if (issue) prio_d = ~grant1;
    // Flush kills everything in flight; the pointer deliberately keeps its value.
    if (flush) begin
      v_c_d   = 1'b0;
      v_n_d   = 1'b0;
      infl0_d = 2'd0;
      infl1_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      v_c_q   <= 1'b0;
      v_n_q   <= 1'b0;
      src_c_q <= 1'b0;
      src_n_q <= 1'b0;
      tag_c_q <= '0;
      tag_n_q <= '0;
      prio_q  <= 1'b0;
      infl0_q <= 2'd0;
      infl1_q <= 2'd0;
    end else begin
      v_c_q   <= v_c_d;
      v_n_q   <= v_n_d;
      src_c_q <= src_c_d;
      src_n_q <= src_n_d;
      tag_c_q <= tag_c_d;
      tag_n_q <= tag_n_d;
      prio_q  <= prio_d;
      infl0_q <= infl0_d;
      infl1_q <= infl1_d;
    end
  end

  assign res_valid = v_n_q;
  assign res_s     = fa_s;
  assign res_src   = src_n_q;
  assign res_tag   = tag_n_q;
  assign inflight0 = infl0_q;
  assign inflight1 = infl1_q;

endmodule

// File: tb/tb_fadd_issue_ctrl.sv
// Bench for fadd_issue_ctrl: stand-in 2-register adder, queue-based reference model,
// directed scenarios followed by a randomized run.
module tb_fadd_issue_ctrl;

  logic        clk = 1'b0;
  logic        clrn, flush;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_sub, req1_sub;
  logic [1:0]  req0_rm, req1_rm;
  logic [3:0]  req0_tag, req1_tag;
  logic [31:0] fa_a, fa_b, fa_s;
  logic        fa_sub, fa_e;
  logic [1:0]  fa_rm;
  logic        res_valid, res_ready, res_src;
  logic [31:0] res_s;
  logic [3:0]  res_tag;
  logic [1:0]  inflight0, inflight1;

  always #5 clk = ~clk;

  fadd_issue_ctrl #(.TAG_W(4)) dut (
    .clk(clk), .clrn(clrn), .flush(flush),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_sub(req0_sub), .req1_sub(req1_sub),
    .req0_rm(req0_rm), .req1_rm(req1_rm),
    .req0_tag(req0_tag), .req1_tag(req1_tag),
    .fa_a(fa_a), .fa_b(fa_b), .fa_sub(fa_sub), .fa_rm(fa_rm), .fa_e(fa_e),
    .fa_s(fa_s),
    .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s),
    .res_src(res_src), .res_tag(res_tag),
    .inflight0(inflight0), .inflight1(inflight1)
  );

  // Stand-in adder: exact for the directed operand pairs, an opaque mix otherwise.
  function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub, input logic [1:0] rm);
    if (a == 32'h3F800000 && b == 32'h40000000 && !sub) return 32'h40400000;
    if (a == 32'h40400000 && b == 32'h3F800000 &&  sub) return 32'h40000000;
    return (a + {b[15:0], b[31:16]}) ^ {29'd0, sub, rm};
  endfunction

  logic [31:0] s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (fa_e) begin
      s1_q <= fake_add(fa_a, fa_b, fa_sub, fa_rm);
      s2_q <= s1_q;
    end
  end
  assign fa_s = s2_q;

  typedef struct {
    logic        src;
    logic [3:0]  tag;
    logic [31:0] sum;
    int          age;
  } op_t;

  op_t  mq[$];
  logic mprio;
  logic e_g0, e_g1, e_fe;
  int   nissued = 0;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_model();
    logic        evld;
    int          c0, c1;
    logic [31:0] ea, eb;
    logic [2:0]  ectl;
    e_g0 = req0_valid && (!req1_valid || !mprio);
    e_g1 = req1_valid && (!req0_valid || mprio);
    evld = (mq.size() > 0) && (mq[0].age == 0);
    e_fe = !(evld && !res_ready);
    c0 = 0;
    c1 = 0;
    foreach (mq[i]) if (mq[i].src) c1++; else c0++;
    ea   = e_g0 ? req0_a : (e_g1 ? req1_a : 32'd0);
    eb   = e_g0 ? req0_b : (e_g1 ? req1_b : 32'd0);
    ectl = e_g0 ? {req0_sub, req0_rm} : (e_g1 ? {req1_sub, req1_rm} : 3'd0);
    chk("res_valid",  64'(res_valid),  64'(evld));
    chk("fa_e",       64'(fa_e),       64'(e_fe));
    chk("req0_ready", 64'(req0_ready), 64'(e_fe && !flush && e_g0));
    chk("req1_ready", 64'(req1_ready), 64'(e_fe && !flush && e_g1));
    chk("inflight0",  64'(inflight0),  64'(c0));
    chk("inflight1",  64'(inflight1),  64'(c1));
    chk("fa_a",       64'(fa_a),       64'(ea));
    chk("fa_b",       64'(fa_b),       64'(eb));
    chk("fa_ctl",     64'({fa_sub, fa_rm}), 64'(ectl));
    if (evld) begin
      chk("res_s",   64'(res_s),   64'(mq[0].sum));
      chk("res_src", 64'(res_src), 64'(mq[0].src));
      chk("res_tag", 64'(res_tag), 64'(mq[0].tag));
    end
  endtask

  task automatic model_update();
    op_t op;
    if (clrn) begin
      mq.delete();
      mprio = 1'b0;
    end else if (flush) begin
      mq.delete();
    end else if (e_fe) begin
      if (mq.size() > 0 && mq[0].age == 0) mq.delete(0);
      for (int i = 0; i < mq.size(); i++) mq[i].age = mq[i].age - 1;
      if (e_g0 || e_g1) begin
        op.src = e_g1;
        op.tag = e_g1 ? req1_tag : req0_tag;
        op.sum = e_g1 ? fake_add(req1_a, req1_b, req1_sub, req1_rm)
                      : fake_add(req0_a, req0_b, req0_sub, req0_rm);
        op.age = 1;
        mq.push_back(op);
        mprio = ~e_g1;
        nissued++;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (chk_en) check_model();
    else begin
      e_g0 = 1'b0;
      e_g1 = 1'b0;
      e_fe = 1'b1;
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    clrn = 1'b0; flush = 1'b0; res_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_sub = 1'b0; req1_sub = 1'b0; req0_rm = 2'd0; req1_rm = 2'd0;
    req0_tag = '0; req1_tag = '0;
  endtask

  initial begin
    int base;
    idle();
    mprio = 1'b0;
    clrn = 1'b1;
    cyc();
    chk_en = 1;
    cyc();
    clrn = 1'b0;
    #1;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_src",   64'(res_src),   64'd0);
    chk("rst_res_tag",   64'(res_tag),   64'd0);
    chk("rst_fa_e",      64'(fa_e),      64'd1);
    chk("rst_inflight",  64'({inflight0, inflight1}), 64'd0);

    // Single add on requester 0.
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_tag = 4'd5;
    #1 chk("single_rdy", 64'(req0_ready), 64'd1);
    cyc();
    req0_valid = 1'b0;
    #1 chk("single_infl1", 64'(inflight0), 64'd1);
    cyc();
    chk("single_vld", 64'(res_valid), 64'd1);
    chk("single_s",   64'(res_s),     64'h40400000);
    chk("single_src", 64'(res_src),   64'd0);
    chk("single_tag", 64'(res_tag),   64'd5);
    cyc();
    chk("single_infl0", 64'(inflight0), 64'd0);

    // Subtract on requester 1.
    req1_valid = 1'b1; req1_a = 32'h40400000; req1_b = 32'h3F800000; req1_sub = 1'b1;
    req1_tag = 4'd9;
    #1 chk("sub_rdy", 64'(req1_ready), 64'd1);
    cyc();
    req1_valid = 1'b0;
    cyc();
    chk("sub_s",   64'(res_s),   64'h40000000);
    chk("sub_src", 64'(res_src), 64'd1);
    chk("sub_tag", 64'(res_tag), 64'd9);
    cyc();

    // Contention straight out of reset.
    clrn = 1'b1;
    cyc();
    clrn = 1'b0;
    for (int k = 0; k < 6; k++) begin
      req0_valid = (k < 4); req1_valid = (k < 4);
      req0_tag = 4'(k); req1_tag = 4'(k);
      #1;
      if (k < 4) chk("cont_rdy0", 64'(req0_ready), 64'(k % 2 == 0));
      if (k >= 2) begin
        chk("cont_vld", 64'(res_valid), 64'd1);
        chk("cont_src", 64'(res_src),   64'((k - 2) % 2));
      end
      cyc();
    end

    // Backpressure on a 3-op stream.
    idle();
    base = nissued;
    for (int k = 0; k < 9; k++) begin
      req0_valid = (nissued - base < 3);
      req0_a = 32'h10000000 + 32'(nissued - base);
      req0_b = 32'h00ABCDEF;
      req0_tag = 4'(nissued - base);
      res_ready = !(k >= 2 && k <= 4);
      #1;
      if (k >= 2 && k <= 4) begin
        chk("bp_fa_e", 64'(fa_e),       64'd0);
        chk("bp_rdy",  64'(req0_ready), 64'd0);
        chk("bp_hold", 64'(res_s),      64'(fake_add(32'h10000000, 32'h00ABCDEF, 1'b0, 2'd0)));
      end
      if (k == 6) chk("bp_res2", 64'(res_tag), 64'd1);
      if (k == 7) chk("bp_res3", 64'(res_tag), 64'd2);
      if (k == 8) chk("bp_done", 64'(res_valid), 64'd0);
      cyc();
    end

    // Flush kills the cycle-0 op and refuses the cycle-1 op.
    idle();
    req0_valid = 1'b1; req0_a = 32'h12345678; req0_tag = 4'd3;
    cyc();
    flush = 1'b1;
    #1 chk("fl_rdy", 64'(req0_ready), 64'd0);
    cyc();
    idle();
    #1;
    chk("fl_vld2", 64'(res_valid), 64'd0);
    chk("fl_infl", 64'({inflight0, inflight1}), 64'd0);
    cyc();
    chk("fl_vld3", 64'(res_valid), 64'd0);
    cyc();

    // Reset with two ops in flight.
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_tag = 4'd7;
    cyc();
    cyc();
    req0_valid = 1'b0; clrn = 1'b1;
    cyc();
    clrn = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; req0_tag = 4'd11;
    #1;
    chk("rm_vld",  64'(res_valid), 64'd0);
    chk("rm_infl", 64'({inflight0, inflight1}), 64'd0);
    chk("rm_prio", 64'(req0_ready), 64'd1);
    cyc();
    idle();
    cyc();
    chk("rm_res_s",   64'(res_s),   64'h40400000);
    chk("rm_res_tag", 64'(res_tag), 64'd11);
    cyc();

    // Randomized traffic with occasional flush, reset and backpressure.
    for (int k = 0; k < 400; k++) begin
      req0_valid = ($urandom_range(0, 99) < 60);
      req1_valid = ($urandom_range(0, 99) < 60);
      req0_a = $urandom(); req0_b = $urandom(); req1_a = $urandom(); req1_b = $urandom();
      req0_sub = 1'($urandom_range(0, 1)); req1_sub = 1'($urandom_range(0, 1));
      req0_rm = 2'($urandom_range(0, 3));  req1_rm = 2'($urandom_range(0, 3));
      req0_tag = 4'($urandom_range(0, 15)); req1_tag = 4'($urandom_range(0, 15));
      res_ready = ($urandom_range(0, 99) < 65);
      flush = ($urandom_range(0, 99) < 4);
      clrn = ($urandom_range(0, 99) < 2);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fadd_issue_ctrl.md
# fadd_issue_ctrl

Issue controller and result sequencer for the 3-stage pipelined single-precision adder (`pipelined_fadder`). It arbitrates two requesters (integer-pipe FP issue port and a second FP client) onto the single adder with round-robin fairness. It drives the adder operands and stage enable `e`, and shadows the adder's two pipeline-register stages with valid/source/tag bits. It returns each sum to the consumer with a valid/ready handshake, stalling the whole adder pipeline under backpressure.

## Interface

- TAG_W, 4, width of the opaque per-request tag carried alongside each operation
- clk  in  1  clock, all state updates on rising edge
- clrn  in  1  reset, synchronous, active-high
- flush  in  1  synchronous kill of all in-flight operations
- req0_valid, req1_valid  in  1  request pending
- req0_ready, req1_ready  out  1  request accepted this cycle
- req0_a/req0_b, req1_a/req1_b  in  32  IEEE-754 single operands
- req0_sub, req1_sub  in  1  1 = a−b, 0 = a+b
- req0_rm, req1_rm  in  2  rounding mode (00 RNE, 01 RTN, 10 RTP, 11 RTZ)
- req0_tag, req1_tag  in  TAG_W  tag returned with result
- fa_a, fa_b  out  32  adder operands
- fa_sub  out  1  adder subtract
- fa_rm  out  2  adder rounding mode
- fa_e  out  1  adder pipeline-register enable
- fa_s  in  32  adder result (combinational from its last register stage)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_s  out  32  result (= fa_s)
- res_src  out  1  requester index of result
- res_tag  out  TAG_W  tag of result
- inflight0, inflight1  out  2  operations in flight per requester (0–2)

## Operation

- Shadow pipeline: stage C (v_c, src_c, tag_c) and stage N (v_n, src_n, tag_n), advancing exactly when fa_e=1, mirroring the adder's register stages.
- Advance: fa_e = ~(v_n & ~res_ready). Stall only when N holds an unconsumed result.
- Output: res_valid = v_n; res_s = fa_s; res_src = src_n; res_tag = tag_n.
- Arbitration: round-robin pointer `prio`. Both valid → grant `prio`, then prio ← other. One valid → grant it, then prio ← other index. No grant → prio unchanged.
- reqX_ready = fa_e & ~flush & grantX. Grant is independent of readiness; ready never asserts for a non-valid requester.
- Operand mux: fa_a/fa_b/fa_sub/fa_rm come from the granted requester. With no grant they are all zero.
- On fa_e=1: v_c ← issue (any reqX_valid & reqX_ready); v_n ← v_c. src/tag load alongside.
- flush=1: v_c, v_n ← 0 next edge; no issue accepted; res_valid may be high that cycle but its handshake is ignored; prio held.
- inflight counters: +1 on accepted issue of that source, −1 on result handshake (res_valid & res_ready) of that source. Both events together → unchanged. Flush/reset → 0.
- Adder clrn is tied to the same reset; adder datapath contents are don't-care whenever the matching shadow valid is 0.

## Timing

- Reset (clrn=1 at edge): v_c=v_n=0, prio=0, inflight0=inflight1=0. Outputs after reset: res_valid=0, res_src=0, res_tag=0, fa_e=1, reqX_ready follows valids/arbitration.
- Latency: accepted in cycle T → res_valid in cycle T+2 with no stalls. Throughput is 1 op/cycle.
- Back-to-back: issue and result handshake in the same cycle are both honoured.
- Stall: while v_n=1 & res_ready=0, fa_e=0, all reqX_ready=0, and res_s/res_src/res_tag stay stable. This holds even when v_c=0 (no bubble collapsing).
- res_valid must not drop without a handshake, except on flush or reset.
- Reset mid-operation: all in-flight results are discarded silently; first res_valid is possible 2 cycles after the first post-reset issue.

## Test plan

- Single op: req0 a=0x3F800000, b=0x40000000, sub=0, rm=00, tag=5 in cycle 0 → req0_ready=1 cycle 0; cycle 2 res_valid=1, res_s=0x40400000, res_src=0, res_tag=5; inflight0 goes 1 then 0 after handshake.
- Subtract: req1 a=0x40400000, b=0x3F800000, sub=1 → res_s=0x40000000, res_src=1, 2-cycle latency.
- Contention: both valid for 4 cycles from reset → grants 0,1,0,1; results return in the same order, one per cycle, from cycle 2.
- Backpressure: stream of 3 ops, res_ready=0 for cycles 2–4 → fa_e=0 and req ready=0 in cycles 2–4, res_s held at first sum. Resume at cycle 5 → remaining results in cycles 6 and 7, none lost or duplicated.
- Flush: issue ops in cycles 0,1, flush=1 in cycle 1 → op in cycle 1 not accepted; no res_valid in cycles 2–3; inflight counters 0 in cycle 2.
- Reset mid-flight: 2 ops in flight, clrn=1 one cycle → res_valid=0, prio=0, inflight=0. A new op issued afterward returns correctly 2 cycles later.
